// File: rtl/bulk_fifo_if.sv
// bulk_fifo_if: valid/ready stream carrying a BITS-wide value.
// Signals: value, valid (producer -> consumer), ready (consumer -> producer).
// Modports: master = producer view, slave = consumer view.
interface bulk_fifo_if #(parameter int BITS = 8);
    logic [BITS-1:0] value;
    logic            valid;
    logic            ready;
    modport master (output value, output valid, input ready);
    modport slave  (input value, input valid, output ready);
endinterface

// File: rtl/bulk_fifo.sv
// bulk_fifo: DEPTH-entry synchronous FIFO between two valid/ready streams.
// Ports: clock, reset (sync, active-high); upstream (slave stream: value/valid in, ready out);
// downstream (master stream: value/valid out, ready in);
// level (occupancy, only when BULK_FIFO_LEVEL_EN is defined).
// Both ready and valid decode from registered count only, so no combinational
// path crosses the FIFO; head value is forced to zero while empty.
module bulk_fifo #(
    parameter int BITS  = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    bulk_fifo_if.slave               upstream,
    bulk_fifo_if.master              downstream
`ifdef BULK_FIFO_LEVEL_EN
    ,
    output logic [$clog2(DEPTH):0]   level
`endif
);
    localparam int AW = $clog2(DEPTH);
    logic [BITS-1:0] mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count;
    logic            push, pop;
    assign upstream.ready   = count != (AW+1)'(DEPTH);
    assign downstream.valid = count != '0;
    assign downstream.value = downstream.valid ? mem[rd_ptr] : '0;
    assign push = upstream.valid && upstream.ready;
    assign pop  = downstream.valid && downstream.ready;
`ifdef BULK_FIFO_LEVEL_EN
    assign level = count;
`endif
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // Storage is not reset: contents are invisible until count says otherwise.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= upstream.value;
    end
endmodule

// File: tb/tb_bulk_fifo.sv
module tb_bulk_fifo;
    logic clock = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    bulk_fifo_if #(.BITS(8)) up ();
    bulk_fifo_if #(.BITS(8)) dn ();
`ifdef BULK_FIFO_LEVEL_EN
    logic [2:0] level;
`endif

    bulk_fifo #(.BITS(8), .DEPTH(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .upstream   (up),
        .downstream (dn)
`ifdef BULK_FIFO_LEVEL_EN
        ,
        .level      (level)
`endif
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lvl(input string tag, input int exp);
`ifdef BULK_FIFO_LEVEL_EN
        chk(tag, 32'(level), 32'(exp));
`endif
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_mvalid"}, 32'(dn.valid), 0);
        chk({tag, "_mvalue"}, 32'(dn.value), 0);
        chk({tag, "_sready"}, 32'(up.ready), 1);
        chk_lvl({tag, "_level"}, 0);
    endtask

    initial begin
        reset    = 1'b1;
        up.valid = 1'b0;
        up.value = 8'h00;
        dn.ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk_empty("reset");

        // single push, 1-cycle latency
        up.valid = 1'b1;
        up.value = 8'h11;
        step();
        up.valid = 1'b0;
        chk("lat_valid", 32'(dn.valid), 1);
        chk("lat_value", 32'(dn.value), 32'h11);
        chk_lvl("lat_level", 1);
        dn.ready = 1'b1;
        step();
        dn.ready = 1'b0;
        chk_empty("pop1");

        // fill to full, fifth word held off
        for (int i = 1; i <= 4; i++) begin
            up.valid = 1'b1;
            up.value = 8'(i);
            step();
        end
        chk("full_sready", 32'(up.ready), 0);
        chk_lvl("full_level", 4);
        chk("full_head", 32'(dn.value), 32'h01);
        up.value = 8'h05;
        step();
        chk("held_sready", 32'(up.ready), 0);
        chk_lvl("held_level", 4);
        chk("held_head", 32'(dn.value), 32'h01);

        // pop while full: no pass-through, slot frees next cycle
        dn.ready = 1'b1;
        step();
        dn.ready = 1'b0;
        chk("fpop_sready", 32'(up.ready), 1);
        chk_lvl("fpop_level", 3);
        chk("fpop_head", 32'(dn.value), 32'h02);
        step();
        up.valid = 1'b0;
        chk("refill_sready", 32'(up.ready), 0);
        chk_lvl("refill_level", 4);
        dn.ready = 1'b1;
        for (int i = 2; i <= 5; i++) begin
            chk("drain_value", 32'(dn.value), 32'(i));
            step();
        end
        dn.ready = 1'b0;
        chk_empty("drain");

        // continuous stream, pointers wrap
        dn.ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            up.valid = 1'b1;
            up.value = 8'(k);
            if (k > 0) begin
                chk("stream_valid", 32'(dn.valid), 1);
                chk("stream_value", 32'(dn.value), 32'(k - 1));
                chk_lvl("stream_level", 1);
            end
            step();
        end
        up.valid = 1'b0;
        chk("stream_last", 32'(dn.value), 32'h0F);
        chk_lvl("stream_last_level", 1);
        step();
        dn.ready = 1'b0;
        chk_empty("stream_end");

        // reset mid-operation dominates push and pop
        for (int i = 0; i < 3; i++) begin
            up.valid = 1'b1;
            up.value = 8'(8'h21 + i);
            step();
        end
        chk_lvl("pre_rst_level", 3);
        chk("pre_rst_head", 32'(dn.value), 32'h21);
        reset    = 1'b1;
        up.value = 8'h99;
        dn.ready = 1'b1;
        step();
        reset    = 1'b0;
        up.valid = 1'b0;
        dn.ready = 1'b0;
        chk_empty("midrst");
        up.valid = 1'b1;
        up.value = 8'hA5;
        step();
        up.valid = 1'b0;
        chk("post_rst_value", 32'(dn.value), 32'hA5);
        chk_lvl("post_rst_level", 1);
        dn.ready = 1'b1;
        step();
        dn.ready = 1'b0;
        chk_empty("post_rst");

        // hold stability then single-cycle ready pulses
        for (int i = 0; i < 4; i++) begin
            up.valid = 1'b1;
            up.value = 8'(8'hC0 + i);
            step();
        end
        up.valid = 1'b0;
        up.value = 8'h3C;
        step();
        step();
        chk("hold_value", 32'(dn.value), 32'hC0);
        chk_lvl("hold_level", 4);
        for (int i = 0; i < 4; i++) begin
            for (int t = 0; t < 10 && !dn.valid; t++) step();
            chk("pulse_wait", 32'(dn.valid), 1);
            chk("pulse_value", 32'(dn.value), 32'(8'hC0 + i));
            dn.ready = 1'b1;
            step();
            dn.ready = 1'b0;
            chk_lvl("pulse_level", 3 - i);
        end
        chk_empty("pulse_end");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
